// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin, burst-limited arbiter sharing one single-port RAM between two requesters
module ram_port_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_data_out
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;
    localparam logic [3:0] LIM = 4'(MAX_BURST - 1);
    owner_t            owner_q, owner_d;
    logic [3:0]        burst_q, burst_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              keep0, keep1;

    // grant selection, RAM drive, read return and next-state
    always_comb begin
        keep0        = owner_q == OWN0 && req0 && (burst_q < LIM || !req1);
        keep1        = owner_q == OWN1 && req1 && (burst_q < LIM || !req0);
        gnt0         = !rst && (owner_q == OWN0 ? keep0 :
                                owner_q == OWN1 ? (!keep1 && req0) :
                                (req0 && (!req1 || rr_last_q)));
        gnt1         = !rst && (owner_q == OWN1 ? keep1 :
                                owner_q == OWN0 ? (!keep0 && req1) :
                                (req1 && (!req0 || !rr_last_q)));
        ram_write_en = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
        ram_addr     = rst ? '0 : gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
        ram_data_in  = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
        addr_d       = ram_addr;
        owner_d      = gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
        burst_d      = ((gnt0 && owner_q == OWN0) || (gnt1 && owner_q == OWN1)) ?
                       (burst_q >= LIM ? LIM : burst_q + 4'd1) : 4'd0;
        rr_last_d    = gnt0 ? 1'b0 : gnt1 ? 1'b1 : rr_last_q;
        rvalid0_d    = gnt0 && !we0;
        rvalid1_d    = gnt1 && !we1;
        rvalid0      = rvalid0_q && !rst;
        rvalid1      = rvalid1_q && !rst;
        rdata0       = rvalid0 ? ram_data_out : '0;
        rdata1       = rvalid1 ? ram_data_out : '0;
    end

    // state registers; reset leaves RAM contents untouched and favours port 0 first
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= IDLE;
            burst_q   <= '0;
            rr_last_q <= 1'b1;
            addr_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed checks of the arbiter against a streak-based reference model
module tb_ram_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 0;
    logic          rst = 1;
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = 0, addr1 = 0;
    logic [DW-1:0] wdata0 = 0, wdata1 = 0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_write_en;
    logic [DW-1:0] rdata0, rdata1, ram_data_in, ram_data_out;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [64];
    logic [AW-1:0] ram_areg = 0;
    bit            ram_ready = 0;

    int checks = 0;
    int failures = 0;

    int            m_owner = -1;
    int            m_streak = 0;
    int            m_rr = 1;
    int            m_w = -1;
    logic [AW-1:0] m_last = 0;
    logic [DW-1:0] m_mem [64];
    bit            m_rv [2] = '{0, 0};
    logic [DW-1:0] m_rd [2];

    bit            e_g0, e_g1, e_we, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd0, e_rd1;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_write_en(ram_write_en), .ram_data_out(ram_data_out)
    );

    // 64x8 RAM: registered read address, write on clock edge
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
            ram_ready <= 1;
        end else if (ram_write_en) mem[ram_addr] <= ram_data_in;
        ram_areg <= ram_addr;
    end
    assign ram_data_out = mem[ram_areg];

    // winner: owner keeps going while its streak is under MAX_BURST or it is alone; else the other side
    task automatic predict();
        bit rq [2];
        rq[0] = req0;
        rq[1] = req1;
        if (rst) m_w = -1;
        else if (m_owner >= 0 && rq[m_owner] && (m_streak < MB || !rq[1-m_owner])) m_w = m_owner;
        else if (rq[0] && rq[1]) m_w = (m_owner >= 0) ? 1 - m_owner : 1 - m_rr;
        else if (rq[0]) m_w = 0;
        else if (rq[1]) m_w = 1;
        else m_w = -1;
        e_g0   = m_w == 0;
        e_g1   = m_w == 1;
        e_we   = m_w == 0 ? we0 : m_w == 1 ? we1 : 1'b0;
        e_addr = rst ? '0 : m_w == 0 ? addr0 : m_w == 1 ? addr1 : m_last;
        e_din  = m_w == 0 ? wdata0 : m_w == 1 ? wdata1 : '0;
        e_rv0  = !rst && m_rv[0];
        e_rv1  = !rst && m_rv[1];
        e_rd0  = e_rv0 ? m_rd[0] : '0;
        e_rd1  = e_rv1 ? m_rd[1] : '0;
    endtask

    task automatic commit();
        logic [AW-1:0] a;
        predict();
        m_rv[0] = 0;
        m_rv[1] = 0;
        if (rst) begin
            m_owner = -1; m_streak = 0; m_rr = 1; m_last = '0;
        end else if (m_w < 0) begin
            m_owner = -1; m_streak = 0;
        end else begin
            a = (m_w == 1) ? addr1 : addr0;
            if ((m_w == 1) ? we1 : we0) m_mem[a] = (m_w == 1) ? wdata1 : wdata0;
            else begin
                m_rv[m_w] = 1;
                m_rd[m_w] = m_mem[a];
            end
            m_streak = (m_owner == m_w) ? m_streak + 1 : 1;
            m_owner  = m_w;
            m_rr     = m_w;
            m_last   = a;
        end
    endtask

    task automatic tick();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 1; addr1 = 2;
        repeat (2) begin
            #1;
            checks++;
            if ({gnt0, gnt1, ram_write_en, rvalid0, rvalid1, ram_addr, ram_data_in, rdata0, rdata1} !== '0) begin
                failures++;
                $display("FAIL reset_outputs gnt=%b%b we=%b rv=%b%b addr=%0d din=%0d rd=%0d/%0d required all zero",
                         gnt0, gnt1, ram_write_en, rvalid0, rvalid1, ram_addr, ram_data_in, rdata0, rdata1);
            end
            tick();
        end
        rst = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        tick();
        req0 = 0; req1 = 0;
        #1;
        predict();
        checks++;
        if (rvalid0 !== e_rv0 || rdata0 !== e_rd0 || rvalid1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_read rv0=%b rd0=%0d rv1=%b required %b %0d 0", rvalid0, rdata0, rvalid1, e_rv0, e_rd0);
        end
        tick();
    endtask

    task automatic test_single_port();
        req0 = 1; we0 = 1; addr0 = 5; wdata0 = 101; req1 = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || ram_write_en !== 1'b1 || ram_addr !== 6'd5 || ram_data_in !== 8'd101) begin
            failures++;
            $display("FAIL single_write gnt0=%b we=%b addr=%0d din=%0d required 1 1 5 101", gnt0, ram_write_en, ram_addr, ram_data_in);
        end
        tick();
        we0 = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || ram_write_en !== 1'b0 || rvalid0 !== 1'b0) begin
            failures++;
            $display("FAIL single_read_grant gnt0=%b we=%b rv0=%b required 1 0 0", gnt0, ram_write_en, rvalid0);
        end
        tick();
        req0 = 0;
        #1;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd101 || rvalid1 !== 1'b0 || gnt0 !== 1'b0 || ram_addr !== 6'd5 || ram_data_in !== 8'd0) begin
            failures++;
            $display("FAIL single_read_data rv0=%b rd0=%0d rv1=%b gnt0=%b addr=%0d din=%0d required 1 101 0 0 5 0",
                     rvalid0, rdata0, rvalid1, gnt0, ram_addr, ram_data_in);
        end
        tick();
        #1;
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'd0) begin
            failures++;
            $display("FAIL single_rvalid_pulse rv0=%b rd0=%0d required 0 0", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_contention();
        bit first, g0, g1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 8;
        for (int i = 0; i < 16; i++) begin
            #1;
            predict();
            checks++;
            if ({gnt0, gnt1, rvalid0, rdata0, rvalid1, rdata1} !== {e_g0, e_g1, e_rv0, e_rd0, e_rv1, e_rd1} || (gnt0 && gnt1)) begin
                failures++;
                $display("FAIL contention i=%0d gnt=%b%b rv0=%b rd0=%0d rv1=%b rd1=%0d required gnt=%b%b rv0=%b rd0=%0d rv1=%b rd1=%0d",
                         i, gnt0, gnt1, rvalid0, rdata0, rvalid1, rdata1, e_g0, e_g1, e_rv0, e_rd0, e_rv1, e_rd1);
            end
            if (i == 0) first = gnt1;
            else begin
                checks++;
                if (gnt1 !== (first ^ ((i / MB) % 2 == 1))) begin
                    failures++;
                    $display("FAIL contention_pattern i=%0d gnt1=%b required %b", i, gnt1, first ^ ((i / MB) % 2 == 1));
                end
            end
            g0 = gnt0; g1 = gnt1;
            tick();
            if (g0) addr0 = addr0 + 1;
            if (g1) addr1 = addr1 + 1;
        end
        req0 = 0; req1 = 0;
        #1;
        predict();
        checks++;
        if ({rvalid0, rdata0, rvalid1, rdata1} !== {e_rv0, e_rd0, e_rv1, e_rd1}) begin
            failures++;
            $display("FAIL contention_drain rv0=%b rd0=%0d rv1=%b rd1=%0d required %b %0d %b %0d",
                     rvalid0, rdata0, rvalid1, rdata1, e_rv0, e_rd0, e_rv1, e_rd1);
        end
        tick();
    endtask

    task automatic test_cross_port();
        req1 = 1; we1 = 1; addr1 = 63; wdata1 = 111; req0 = 0;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || ram_write_en !== 1'b1 || ram_addr !== 6'd63) begin
            failures++;
            $display("FAIL cross_write gnt1=%b we=%b addr=%0d required 1 1 63", gnt1, ram_write_en, ram_addr);
        end
        tick();
        req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 63;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || rvalid1 !== 1'b0) begin
            failures++;
            $display("FAIL cross_read_grant gnt0=%b gnt1=%b rv1=%b required 1 0 0", gnt0, gnt1, rvalid1);
        end
        tick();
        req0 = 0;
        #1;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'd111) begin
            failures++;
            $display("FAIL cross_read_data rv0=%b rd0=%0d required 1 111", rvalid0, rdata0);
        end
        tick();
    endtask

    task automatic test_owner_release();
        req0 = 1; we0 = 0; addr0 = 3; req1 = 0;
        repeat (2) begin
            #1;
            checks++;
            if (gnt0 !== 1'b1) begin
                failures++;
                $display("FAIL release_burst gnt0=%b required 1", gnt0);
            end
            tick();
        end
        req0 = 0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_write_en !== 1'b0) begin
            failures++;
            $display("FAIL release_idle gnt=%b%b we=%b required 00 0", gnt0, gnt1, ram_write_en);
        end
        tick();
        req0 = 1; req1 = 1; we1 = 0; addr1 = 4;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL release_rr gnt0=%b gnt1=%b required 0 1", gnt0, gnt1);
        end
        tick();
        req0 = 0; req1 = 0;
        #1;
        tick();
    endtask

    task automatic test_mid_reset();
        req1 = 1; we1 = 1; addr1 = 10; wdata1 = 77; req0 = 0;
        #1;
        tick();
        we1 = 0; rst = 1; req0 = 1; we0 = 1; addr0 = 10; wdata0 = 99;
        #1;
        checks++;
        if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || ram_write_en !== 1'b0) begin
            failures++;
            $display("FAIL midreset_grant gnt=%b%b we=%b required 00 0", gnt0, gnt1, ram_write_en);
        end
        tick();
        rst = 0; req1 = 0; req0 = 0;
        #1;
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 8'd0) begin
            failures++;
            $display("FAIL midreset_rvalid rv1=%b rd1=%0d required 0 0", rvalid1, rdata1);
        end
        tick();
        req1 = 1;
        #1;
        tick();
        req1 = 0;
        #1;
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'd77) begin
            failures++;
            $display("FAIL midreset_retain rv1=%b rd1=%0d required 1 77", rvalid1, rdata1);
        end
        tick();
    endtask

    task automatic test_random();
        bit gp0 = 0, gp1 = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!req0 || gp0) begin
                req0 = ($urandom_range(0, 3) != 0); we0 = ($urandom_range(0, 2) == 0);
                addr0 = 6'($urandom_range(0, 7)); wdata0 = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) req0 = 0;
            if (!req1 || gp1) begin
                req1 = ($urandom_range(0, 3) != 0); we1 = ($urandom_range(0, 2) == 0);
                addr1 = 6'($urandom_range(0, 7)); wdata1 = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) req1 = 0;
            #1;
            predict();
            checks++;
            if ({gnt0, gnt1, ram_write_en, ram_addr, ram_data_in, rvalid0, rdata0, rvalid1, rdata1} !==
                {e_g0, e_g1, e_we, e_addr, e_din, e_rv0, e_rd0, e_rv1, e_rd1}) begin
                failures++;
                $display("FAIL random c=%0d got g=%b%b we=%b a=%0d d=%0d rv0=%b rd0=%0d rv1=%b rd1=%0d required g=%b%b we=%b a=%0d d=%0d rv0=%b rd0=%0d rv1=%b rd1=%0d",
                         c, gnt0, gnt1, ram_write_en, ram_addr, ram_data_in, rvalid0, rdata0, rvalid1, rdata1,
                         e_g0, e_g1, e_we, e_addr, e_din, e_rv0, e_rd0, e_rv1, e_rd1);
            end
            gp0 = gnt0; gp1 = gnt1;
            tick();
        end
        rst = 0; req0 = 0; req1 = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = 8'(i * 7 + 3);
        @(posedge clk);
        #1;
        test_reset();
        test_single_port();
        test_contention();
        test_cross_port();
        test_owner_release();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
